// File: rtl/stream_pkg.sv
// Shared types and constants for the two-requester block stream arbiter.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic TYPE_KEY  = 1'b1;
    localparam logic TYPE_DATA = 1'b0;
    localparam int   BEATS_DEF = 8;

endpackage

// File: rtl/stream_arb.sv
// Block-granular arbiter between a key and a data beat stream feeding a deserializer.
// Optional key priority: define STREAM_ARB_KEY_PRIO_EN; otherwise round-robin on last_owner.
module stream_arb
    import stream_pkg::*;
#(
    parameter int BEATS = BEATS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        k_req,
    input  logic [15:0] k_din,
    output logic        k_ack,
    input  logic        d_req,
    input  logic [15:0] d_din,
    output logic        d_ack,
    output logic        vout,
    output logic        tout,
    output logic [15:0] dout,
    output logic        busy,
    output logic        blk_done,
    output state_t      state_dbg
);

    localparam int            CW   = $clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_owner;
    logic          grant_key;
    logic          acc;
    logic [15:0]   own_din;

    // Handshake: the owner's ack follows its req in the same cycle; a beat is
    // transferred when req && ack, and the non-owner is never acked.
    always_comb begin
        k_ack   = (state == KEY) && k_req;
        d_ack   = (state == DATA) && d_req;
        acc     = k_ack || d_ack;
        own_din = (state == KEY) ? k_din : d_din;
`ifdef STREAM_ARB_KEY_PRIO_EN
        grant_key = k_req;
`else
        grant_key = k_req && (!d_req || (last_owner == TYPE_DATA));
`endif
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= TYPE_DATA;
            vout       <= 1'b0;
            tout       <= 1'b0;
            dout       <= '0;
            blk_done   <= 1'b0;
        end else begin
            vout     <= acc;
            blk_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (k_req || d_req) begin
                        if (grant_key) begin
                            state      <= KEY;
                            last_owner <= TYPE_KEY;
                        end else begin
                            state      <= DATA;
                            last_owner <= TYPE_DATA;
                        end
                    end
                end
                KEY, DATA: begin
                    if (acc) begin
                        dout <= own_din;
                        tout <= (state == KEY) ? TYPE_KEY : TYPE_DATA;
                        // Last beat of the block: release ownership, one bubble follows.
                        if (cnt == LAST) begin
                            cnt      <= '0;
                            blk_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_arb.sv
// Directed bench for stream_arb: single-owner block, gaps, mid-burst reset, arbitration.
module tb_stream_arb;
    import stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        k_req;
    logic [15:0] k_din;
    logic        k_ack;
    logic        d_req;
    logic [15:0] d_din;
    logic        d_ack;
    logic        vout;
    logic        tout;
    logic [15:0] dout;
    logic        busy;
    logic        blk_done;
    state_t      state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_t;

    stream_arb #(.BEATS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .k_req    (k_req),
        .k_din    (k_din),
        .k_ack    (k_ack),
        .d_req    (d_req),
        .d_din    (d_din),
        .d_ack    (d_ack),
        .vout     (vout),
        .tout     (tout),
        .dout     (dout),
        .busy     (busy),
        .blk_done (blk_done),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b0;
        k_req = 1'b0;
        d_req = 1'b0;
        k_din = '0;
        d_din = '0;
        tick();
        tick();
        settle();
        chk("rst_vout", vout, 0);
        chk("rst_tout", tout, 0);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_blk_done", blk_done, 0);
        chk("rst_state", state_dbg, IDLE);
        chk("rst_kack", k_ack, 0);
        chk("rst_dack", d_ack, 0);
        rst = 1'b1;
        tick();

        // Key-only block of 0001..0008
        k_req = 1'b1;
        k_din = 16'h0001;
        settle();
        chk("a_idle_kack", k_ack, 0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            k_din = 16'(i);
            settle();
            chk($sformatf("a_kack%0d", i), k_ack, 1);
            chk($sformatf("a_dack%0d", i), d_ack, 0);
            chk($sformatf("a_busy%0d", i), busy, 1);
            if (i == 1) begin
                chk("a_vout_first", vout, 0);
            end else begin
                chk($sformatf("a_vout%0d", i - 1), vout, 1);
                chk($sformatf("a_dout%0d", i - 1), dout, i - 1);
                chk($sformatf("a_tout%0d", i - 1), tout, 1);
                chk($sformatf("a_done%0d", i - 1), blk_done, 0);
            end
            tick();
        end
        chk("a_vout8", vout, 1);
        chk("a_dout8", dout, 16'h0008);
        chk("a_tout8", tout, 1);
        chk("a_done8", blk_done, 1);
        chk("a_busy_idle", busy, 0);
        k_req = 1'b0;
        settle();
        chk("a_bubble_kack", k_ack, 0);
        tick();
        chk("a_post_vout", vout, 0);
        chk("a_post_done", blk_done, 0);
        chk("a_post_dout_hold", dout, 16'h0008);
        chk("a_post_tout_hold", tout, 1);

        // Data request during a key block, then data block with a 4-cycle gap
        k_req = 1'b1;
        tick();
        d_req = 1'b1;
        d_din = 16'hD001;
        for (int i = 1; i <= 8; i++) begin
            k_din = 16'h0100 + 16'(i);
            settle();
            chk($sformatf("b_kack%0d", i), k_ack, 1);
            chk($sformatf("b_dack%0d", i), d_ack, 0);
            tick();
        end
        chk("b_key_done", blk_done, 1);
        chk("b_key_dout", dout, 16'h0108);
        k_req = 1'b0;
        settle();
        chk("b_idle_dack", d_ack, 0);
        chk("b_idle_busy", busy, 0);
        tick();
        for (int j = 1; j <= 3; j++) begin
            d_din = 16'hD000 + 16'(j);
            settle();
            chk($sformatf("b_dack%0d", j), d_ack, 1);
            chk($sformatf("b_kack_d%0d", j), k_ack, 0);
            tick();
            chk($sformatf("b_vout%0d", j), vout, 1);
            chk($sformatf("b_dout%0d", j), dout, 16'hD000 + j);
            chk($sformatf("b_tout%0d", j), tout, 0);
        end
        d_req = 1'b0;
        for (int g = 0; g < 4; g++) begin
            settle();
            chk($sformatf("b_gap_dack%0d", g), d_ack, 0);
            chk($sformatf("b_gap_busy%0d", g), busy, 1);
            tick();
            chk($sformatf("b_gap_vout%0d", g), vout, 0);
        end
        d_req = 1'b1;
        for (int j = 4; j <= 8; j++) begin
            d_din = 16'hD000 + 16'(j);
            settle();
            chk($sformatf("b_dack%0d", j), d_ack, 1);
            tick();
            chk($sformatf("b_vout%0d", j), vout, 1);
            chk($sformatf("b_dout%0d", j), dout, 16'hD000 + j);
            chk($sformatf("b_done%0d", j), blk_done, (j == 8) ? 1 : 0);
        end
        d_req = 1'b0;
        settle();
        chk("b_end_busy", busy, 0);
        tick();

        // Reset after 5 data beats, then a clean data block
        d_req = 1'b1;
        tick();
        for (int j = 1; j <= 5; j++) begin
            d_din = 16'hE000 + 16'(j);
            settle();
            tick();
        end
        chk("c_pre_dout", dout, 16'hE005);
        chk("c_pre_vout", vout, 1);
        rst = 1'b0;
        tick();
        chk("c_rst_vout", vout, 0);
        chk("c_rst_busy", busy, 0);
        chk("c_rst_dout", dout, 0);
        chk("c_rst_tout", tout, 0);
        chk("c_rst_done", blk_done, 0);
        chk("c_rst_state", state_dbg, IDLE);
        rst = 1'b1;
        settle();
        chk("c_idle_dack", d_ack, 0);
        tick();
        for (int j = 1; j <= 8; j++) begin
            d_din = 16'hF000 + 16'(j);
            settle();
            chk($sformatf("c_dack%0d", j), d_ack, 1);
            tick();
            chk($sformatf("c_vout%0d", j), vout, 1);
            chk($sformatf("c_dout%0d", j), dout, 16'hF000 + j);
            chk($sformatf("c_done%0d", j), blk_done, (j == 8) ? 1 : 0);
        end
        d_req = 1'b0;
        tick();

        // Both requesters held from reset: arbitration across three blocks
        rst   = 1'b0;
        k_req = 1'b1;
        d_req = 1'b1;
        k_din = 16'hAAAA;
        d_din = 16'h5555;
        tick();
        rst = 1'b1;
`ifdef STREAM_ARB_KEY_PRIO_EN
        exp_t = 3'b111;
`else
        exp_t = 3'b101;
`endif
        for (int b = 0; b < 3; b++) begin
            settle();
            chk($sformatf("d_idle_kack%0d", b), k_ack, 0);
            chk($sformatf("d_idle_dack%0d", b), d_ack, 0);
            tick();
            settle();
            chk($sformatf("d_kack%0d", b), k_ack, exp_t[b]);
            chk($sformatf("d_dack%0d", b), d_ack, !exp_t[b]);
            repeat (8) tick();
            chk($sformatf("d_tout%0d", b), tout, exp_t[b]);
            chk($sformatf("d_dout%0d", b), dout, exp_t[b] ? 16'hAAAA : 16'h5555);
            chk($sformatf("d_done%0d", b), blk_done, 1);
            chk($sformatf("d_vout%0d", b), vout, 1);
        end
        k_req = 1'b0;
        d_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
